// File: rtl/note_lane_engine.sv
// note_lane_engine: four-lane falling-note tracker with PS/2 key judging.
// Each lane holds at most one note. Notes advance on frame_tick, are missed
// at the bottom of the screen, and are hit by a key press inside the window.
//
// keyState | meaning
// ---------+---------------------------------------------
// IDLE     | expecting a make code or a prefix byte
// BRK      | F0 seen; next byte is a released key
// EXT      | E0 seen; extended key follows (not a lane)
// BRK_EXT  | E0 F0 seen; next byte is a released extended key
module note_lane_engine #(
  parameter int SPEED  = 1,
  parameter int HIT_Y  = 400,
  parameter int WINDOW = 16,
  parameter int BOTTOM = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        spawn_valid,
  input  logic [1:0]  spawn_lane,
  output logic        spawn_ready,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic [39:0] note_y,
  output logic [3:0]  note_active,
  output logic        hit_pulse,
  output logic [1:0]  hit_lane,
  output logic [3:0]  miss_mask,
  output logic [15:0] score
);

  localparam logic [10:0] SpeedW  = 11'(SPEED);
  localparam logic [10:0] WinLo   = 11'(HIT_Y - WINDOW);
  localparam logic [10:0] WinHi   = 11'(HIT_Y + WINDOW);
  localparam logic [10:0] BottomW = 11'(BOTTOM);

  typedef enum logic [1:0] {IDLE, BRK, EXT, BRK_EXT} keyState_t;

  keyState_t   keyState;
  logic [3:0]  held;
  logic        codeIsLane;
  logic [1:0]  codeLane;
  logic        makeEvt;
  logic        press;
  logic        hitNow;
  logic        spawnAccept;
  logic [9:0]  curY;
  logic [10:0] advY [4];

  assign spawn_ready = ~note_active[spawn_lane];
  assign spawnAccept = spawn_valid && spawn_ready;

  // Map the four lane scan codes onto lane indices.
  always_comb begin
    codeIsLane = 1'b1;
    codeLane   = 2'd0;
    case (key_code)
      8'h1C:   codeLane = 2'd0;
      8'h1B:   codeLane = 2'd1;
      8'h23:   codeLane = 2'd2;
      8'h2B:   codeLane = 2'd3;
      default: codeIsLane = 1'b0;
    endcase
  end

  // Press detection and hit judgement against the lane's current Y.
  always_comb begin
    makeEvt = key_valid && (keyState == IDLE) && codeIsLane;
    press   = makeEvt && !held[codeLane];
    curY    = note_y[10*codeLane +: 10];
    hitNow  = press && note_active[codeLane] &&
              ({1'b0, curY} >= WinLo) && ({1'b0, curY} <= WinHi);
  end

  // Per-lane advanced Y, widened so the bottom compare cannot wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      advY[i] = {1'b0, note_y[10*i +: 10]} + SpeedW;
    end
  end

  // Scan-code decoder and held-key tracking; only moves on key_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      keyState <= IDLE;
      held     <= 4'b0;
    end else if (key_valid) begin
      case (keyState)
        IDLE: begin
          if (key_code == 8'hF0) keyState <= BRK;
          else if (key_code == 8'hE0) keyState <= EXT;
          else if (press) held[codeLane] <= 1'b1;
        end
        BRK: begin
          keyState <= IDLE;
          if (codeIsLane) held[codeLane] <= 1'b0;
        end
        EXT: begin
          keyState <= (key_code == 8'hF0) ? BRK_EXT : IDLE;
        end
        BRK_EXT: keyState <= IDLE;
        default: keyState <= IDLE;
      endcase
    end
  end

  // Lane state, hit/miss pulses and score. A hit beats a same-cycle advance;
  // spawns only land on inactive lanes, so they never collide with either.
  always_ff @(posedge clk) begin
    if (reset) begin
      note_y      <= '0;
      note_active <= '0;
      hit_pulse   <= 1'b0;
      hit_lane    <= 2'd0;
      miss_mask   <= '0;
      score       <= '0;
    end else begin
      hit_pulse <= hitNow;
      miss_mask <= '0;
      if (hitNow) begin
        hit_lane <= codeLane;
        if (score != 16'hFFFF) score <= score + 16'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (hitNow && (codeLane == 2'(i))) begin
          note_active[i]     <= 1'b0;
          note_y[10*i +: 10] <= '0;
        end else if (frame_tick && note_active[i]) begin
          if (advY[i] >= BottomW) begin
            note_active[i]     <= 1'b0;
            note_y[10*i +: 10] <= '0;
            miss_mask[i]       <= 1'b1;
          end else begin
            note_y[10*i +: 10] <= advY[i][9:0];
          end
        end else if (spawnAccept && (spawn_lane == 2'(i))) begin
          note_active[i]     <= 1'b1;
          note_y[10*i +: 10] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_lane_engine.sv
// Bench for note_lane_engine: directed scenarios plus random traffic, with a
// behavioural model producing expected outputs into a queue that a separate
// monitor drains and compares one cycle later.
module tb_note_lane_engine;

  localparam int SPEED  = 1;
  localparam int HIT_Y  = 400;
  localparam int WINDOW = 16;
  localparam int BOTTOM = 480;

  logic        clk = 1'b0;
  logic        reset, frame_tick, spawn_valid, key_valid;
  logic [1:0]  spawn_lane;
  logic [7:0]  key_code;
  logic        spawn_ready, hit_pulse;
  logic [39:0] note_y;
  logic [3:0]  note_active, miss_mask;
  logic [1:0]  hit_lane;
  logic [15:0] score;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [39:0] y;
    logic [3:0]  act;
    logic        hp;
    logic [1:0]  hl;
    logic [3:0]  miss;
    logic [15:0] score;
  } exp_t;

  exp_t expQ[$];

  // Reference model state
  int   my[4];
  bit   ma[4];
  bit   mh[4];
  int   mscore;
  int   mhl;
  logic [7:0] pend[$];

  note_lane_engine #(.SPEED(SPEED), .HIT_Y(HIT_Y), .WINDOW(WINDOW), .BOTTOM(BOTTOM)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
    .key_valid(key_valid), .key_code(key_code),
    .note_y(note_y), .note_active(note_active),
    .hit_pulse(hit_pulse), .hit_lane(hit_lane), .miss_mask(miss_mask), .score(score)
  );

  always #5 clk = ~clk;

  function automatic int laneOf(input logic [7:0] c);
    case (c)
      8'h1C: return 0;
      8'h1B: return 1;
      8'h23: return 2;
      8'h2B: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    reset = 0; frame_tick = 0; spawn_valid = 0; spawn_lane = 0;
    key_valid = 0; key_code = 0;
  endtask

  // Apply the currently driven inputs for one clock, predicting the result.
  task automatic step();
    exp_t e;
    int   ev, lane, ny;
    bit   hit;
    bit   actBefore[4];
    logic [3:0] miss;
    #1;
    chk("spawn_ready", {39'b0, spawn_ready}, {39'b0, !ma[spawn_lane]});
    miss = 4'b0;
    hit  = 0;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin my[i] = 0; ma[i] = 0; mh[i] = 0; end
      mscore = 0; mhl = 0; pend.delete();
    end else begin
      ev = 0;
      lane = laneOf(key_code);
      if (key_valid) begin
        if (pend.size() == 0 && (key_code == 8'hF0 || key_code == 8'hE0))
          pend.push_back(key_code);
        else if (pend.size() == 1 && pend[0] == 8'hE0 && key_code == 8'hF0)
          pend.push_back(key_code);
        else begin
          if (pend.size() == 0 && lane >= 0) ev = 1;
          else if (pend.size() == 1 && pend[0] == 8'hF0 && lane >= 0) ev = 2;
          pend.delete();
        end
      end
      if (ev == 1 && !mh[lane]) begin
        mh[lane] = 1;
        hit = ma[lane] && my[lane] >= HIT_Y - WINDOW && my[lane] <= HIT_Y + WINDOW;
      end
      if (ev == 2) mh[lane] = 0;
      actBefore = ma;
      for (int i = 0; i < 4; i++) begin
        if (hit && lane == i) begin
          ma[i] = 0; my[i] = 0;
        end else if (frame_tick && ma[i]) begin
          ny = my[i] + SPEED;
          if (ny >= BOTTOM) begin ma[i] = 0; my[i] = 0; miss[i] = 1'b1; end
          else my[i] = ny;
        end
      end
      if (spawn_valid && !actBefore[spawn_lane]) begin
        ma[spawn_lane] = 1; my[spawn_lane] = 0;
      end
      if (hit) begin
        mhl = lane;
        if (mscore < 65535) mscore++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      e.y[10*i +: 10] = 10'(my[i]);
      e.act[i] = ma[i];
    end
    e.hp = hit; e.hl = 2'(mhl); e.miss = miss; e.score = 16'(mscore);
    expQ.push_back(e);
    @(posedge clk);
    #2;
    clearInputs();
  endtask

  task automatic doReset();
    reset = 1; step();
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin frame_tick = 1; step(); end
  endtask
  task automatic spawn(input int l);
    spawn_valid = 1; spawn_lane = 2'(l); step();
  endtask
  task automatic key(input logic [7:0] b);
    key_valid = 1; key_code = b; step();
  endtask

  // Monitor: compare DUT outputs against the oldest prediction each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("note_y",      note_y,              e.y);
        chk("note_active", {36'b0, note_active}, {36'b0, e.act});
        chk("hit_pulse",   {39'b0, hit_pulse},  {39'b0, e.hp});
        chk("hit_lane",    {38'b0, hit_lane},   {38'b0, e.hl});
        chk("miss_mask",   {36'b0, miss_mask},  {36'b0, e.miss});
        chk("score",       {24'b0, score},      {24'b0, e.score});
      end
    end
  end

  initial begin
    logic [7:0] codes [8];
    codes[0] = 8'h1C; codes[1] = 8'h1B; codes[2] = 8'h23; codes[3] = 8'h2B;
    codes[4] = 8'hF0; codes[5] = 8'hE0; codes[6] = 8'h1C; codes[7] = 8'h29;
    for (int i = 0; i < 4; i++) begin my[i] = 0; ma[i] = 0; mh[i] = 0; end
    mscore = 0; mhl = 0;
    clearInputs();
    reset = 1;
    @(posedge clk);
    #2;
    doReset();
    doReset();

    // lane2 reaches Y=400 and is hit
    spawn(2); ticks(400); key(8'h23); key(8'hF0); key(8'h23);

    // lane0 falls to the bottom and misses on tick 480
    spawn(0); ticks(480); ticks(2);

    // typematic repeats give a single hit; release then a fresh press hits again
    spawn(1); ticks(390); key(8'h1B); key(8'h1B); key(8'h1B);
    spawn(1); ticks(390); key(8'hF0); key(8'h1B); key(8'h1B);
    key(8'hF0); key(8'h1B);

    // extended codes are ignored; a plain make afterwards hits
    spawn(0); ticks(400); key(8'hE0); key(8'h1C);
    key(8'hE0); key(8'hF0); key(8'h1C); key(8'h1C);
    key(8'hF0); key(8'h1C);

    // window edges on lane3, then hit racing a frame tick
    spawn(3); ticks(383); key(8'h2B); key(8'hF0); key(8'h2B);
    ticks(1); key(8'h2B); key(8'hF0); key(8'h2B);
    spawn(3); ticks(416);
    key_valid = 1; key_code = 8'h2B; frame_tick = 1; step();
    key(8'hF0); key(8'h2B);
    spawn(3); ticks(417); key(8'h2B); key(8'hF0); key(8'h2B);

    // score saturation
    force dut.score = 16'hFFFF;
    #1;
    release dut.score;
    mscore = 65535;
    spawn(2); ticks(400); key(8'h23); key(8'hF0); key(8'h23);

    // spawn refused on an active lane, including its miss cycle
    spawn(0); ticks(5); spawn(0); ticks(474);
    spawn_valid = 1; spawn_lane = 2'd0; frame_tick = 1; step();
    spawn(0);

    // mid-operation reset with activity in flight
    spawn(1); ticks(20); spawn(3); key(8'h1C);
    reset = 1; spawn_valid = 1; spawn_lane = 2'd2; frame_tick = 1; step();
    key(8'hF0); key(8'h1C); spawn(2); ticks(3);

    // random traffic
    for (int n = 0; n < 6000; n++) begin
      reset       = ($urandom_range(0, 1999) == 0);
      frame_tick  = 1'($urandom_range(0, 1));
      spawn_valid = ($urandom_range(0, 3) == 0);
      spawn_lane  = 2'($urandom_range(0, 3));
      key_valid   = ($urandom_range(0, 3) == 0);
      key_code    = codes[$urandom_range(0, 7)];
      step();
    end

    repeat (3) @(posedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
